// File: rtl/camera_cfg_sequencer_pkg.sv
// Shared constants, state types and helpers for the camera register-ROM sequencer
// and its SCCB write engine.
package camera_cfg_sequencer_pkg;

   localparam logic [7:0]  SCCB_SWRST_ADDR = 8'h12;
   localparam logic [7:0]  DEF_DEV_ADDR    = 8'h60;
   localparam int unsigned BITS_PER_PHASE  = 9;
   localparam int unsigned PHASES          = 3;
   localparam int unsigned SETTLE_CYCLES   = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PWR_WAIT,
      ST_SETTLE,
      ST_XFER,
      ST_SW_RST_WAIT,
      ST_ADVANCE,
      ST_DONE
   } seq_state_t;

   typedef enum logic [2:0] {
      EN_IDLE,
      EN_START,
      EN_TX,
      EN_STOP,
      EN_FREE
   } eng_state_t;

   function automatic int unsigned qdiv_calc(input int unsigned clk_hz, input int unsigned sccb_hz);
      int unsigned q;
      q = clk_hz / (4 * sccb_hz);
      return (q == 0) ? 1 : q;
   endfunction

   // A write of bit7 to COM7 resets the sensor and needs a recovery wait.
   function automatic logic is_soft_reset(input logic [7:0] reg_addr, input logic [7:0] value);
      return (reg_addr == SCCB_SWRST_ADDR) && value[7];
   endfunction

endpackage

// File: rtl/camera_cfg_sequencer_sccb_write_engine.sv
// SCCB 3-phase write engine: quarter-bit divider, start, 27-bit shift, stop and a
// one-bit bus-free gap before reporting completion.
module sccb_write_engine
   import camera_cfg_sequencer_pkg::*;
#(
   parameter int unsigned QDIV = 62
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       go_i,
   input  logic [7:0] dev_i,
   input  logic [7:0] reg_i,
   input  logic [7:0] val_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       sio_c_o,
   output logic       sio_d_o,
   output logic       sio_d_oe_o
);

   localparam int unsigned    QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [QW-1:0]  QLAST = QW'(QDIV - 1);

   eng_state_t    state_q;
   logic [QW-1:0] qdiv_q;
   logic [1:0]    quarter_q;
   logic [3:0]    pbit_q;
   logic [1:0]    phase_q;
   logic [23:0]   shift_q;
   logic          sio_c_q;
   logic          sio_d_q;
   logic          sio_oe_q;
   logic          done_q;
   logic          tick;

   assign tick = (state_q != EN_IDLE) && (qdiv_q == QLAST);

   // Outputs are updated on the tick that ends a quarter, so each register value
   // describes the quarter that is about to begin.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= EN_IDLE;
         qdiv_q    <= '0;
         quarter_q <= '0;
         pbit_q    <= '0;
         phase_q   <= '0;
         shift_q   <= '0;
         sio_c_q   <= 1'b1;
         sio_d_q   <= 1'b1;
         sio_oe_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != EN_IDLE) begin
            qdiv_q <= tick ? '0 : qdiv_q + 1'b1;
         end
         unique case (state_q)
            EN_IDLE: begin
               if (go_i) begin
                  state_q   <= EN_START;
                  qdiv_q    <= '0;
                  quarter_q <= '0;
                  pbit_q    <= '0;
                  phase_q   <= '0;
                  shift_q   <= {dev_i, reg_i, val_i};
                  sio_c_q   <= 1'b1;
                  sio_d_q   <= 1'b1;
                  sio_oe_q  <= 1'b1;
               end
            end
            EN_START: begin
               if (tick) begin
                  if (quarter_q == 2'd0) begin
                     quarter_q <= 2'd1;
                     sio_d_q   <= 1'b0;
                  end else begin
                     state_q   <= EN_TX;
                     quarter_q <= 2'd0;
                     sio_c_q   <= 1'b0;
                     sio_d_q   <= shift_q[23];
                     sio_oe_q  <= 1'b1;
                     shift_q   <= {shift_q[22:0], 1'b0};
                  end
               end
            end
            EN_TX: begin
               if (tick) begin
                  quarter_q <= quarter_q + 1'b1;
                  if (quarter_q == 2'd1) begin
                     sio_c_q <= 1'b1;
                  end
                  if (quarter_q == 2'd3) begin
                     sio_c_q <= 1'b0;
                     if (phase_q == 2'(PHASES - 1) && pbit_q == 4'(BITS_PER_PHASE - 1)) begin
                        state_q  <= EN_STOP;
                        sio_d_q  <= 1'b0;
                        sio_oe_q <= 1'b1;
                     end else if (pbit_q == 4'(BITS_PER_PHASE - 1)) begin
                        pbit_q   <= '0;
                        phase_q  <= phase_q + 1'b1;
                        sio_d_q  <= shift_q[23];
                        sio_oe_q <= 1'b1;
                        shift_q  <= {shift_q[22:0], 1'b0};
                     end else if (pbit_q == 4'(BITS_PER_PHASE - 2)) begin
                        // Ninth bit: release the line; the sensor's answer is not sampled.
                        pbit_q   <= pbit_q + 1'b1;
                        sio_d_q  <= 1'b1;
                        sio_oe_q <= 1'b0;
                     end else begin
                        pbit_q   <= pbit_q + 1'b1;
                        sio_d_q  <= shift_q[23];
                        sio_oe_q <= 1'b1;
                        shift_q  <= {shift_q[22:0], 1'b0};
                     end
                  end
               end
            end
            EN_STOP: begin
               if (tick) begin
                  if (quarter_q == 2'd0) begin
                     quarter_q <= 2'd1;
                     sio_c_q   <= 1'b1;
                  end else begin
                     state_q   <= EN_FREE;
                     quarter_q <= 2'd0;
                     sio_c_q   <= 1'b1;
                     sio_d_q   <= 1'b1;
                     sio_oe_q  <= 1'b0;
                  end
               end
            end
            EN_FREE: begin
               if (tick) begin
                  quarter_q <= quarter_q + 1'b1;
                  if (quarter_q == 2'd3) begin
                     state_q <= EN_IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= EN_IDLE;
         endcase
      end
   end

   assign busy_o     = (state_q != EN_IDLE);
   assign done_o     = done_q;
   assign sio_c_o    = sio_c_q;
   assign sio_d_o    = sio_d_q;
   assign sio_d_oe_o = sio_oe_q;

endmodule

// File: rtl/camera_cfg_sequencer.sv
// Power-up sequencer: walks the camera register ROM and writes every entry to the
// sensor over SCCB, then raises a sticky cfg_done.
module camera_cfg_sequencer
   import camera_cfg_sequencer_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 25_000_000,
   parameter int unsigned SCCB_HZ      = 100_000,
   parameter logic [7:0]  DEV_ADDR     = DEF_DEV_ADDR,
   parameter int unsigned PWRUP_CYCLES = 25_000,
   parameter int unsigned SWRST_CYCLES = 25_000
) (
   input  logic        camera_clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] rom_data,
   input  logic        rom_not_done,
   output logic        rom_next,
   output logic        sio_c,
   output logic        sio_d_o,
   output logic        sio_d_oe,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic [7:0]  reg_count
);

   localparam int unsigned QDIV = qdiv_calc(CLK_HZ, SCCB_HZ);

   seq_state_t  state_q;
   logic [31:0] dly_q;
   logic        armed_q;
   logic        go_q;
   logic [7:0]  ra_q;
   logic [7:0]  val_q;
   logic        rom_next_q;
   logic        busy_q;
   logic        done_q;
   logic [7:0]  reg_count_q;
   logic [7:0]  reg_count_d;
   logic        eng_busy;
   logic        eng_done;

   assign reg_count_d = (reg_count_q == 8'hFF) ? reg_count_q : reg_count_q + 8'd1;

   // armed_q blocks a start pulse that coincides with the first edge after reset release.
   always_ff @(posedge camera_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         dly_q       <= '0;
         armed_q     <= 1'b0;
         go_q        <= 1'b0;
         ra_q        <= '0;
         val_q       <= '0;
         rom_next_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         reg_count_q <= '0;
      end else begin
         armed_q    <= 1'b1;
         go_q       <= 1'b0;
         rom_next_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start && armed_q) begin
                  state_q <= ST_PWR_WAIT;
                  dly_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_PWR_WAIT: begin
               if (dly_q == 32'(PWRUP_CYCLES - 1)) begin
                  state_q <= ST_SETTLE;
                  dly_q   <= '0;
               end else begin
                  dly_q <= dly_q + 32'd1;
               end
            end
            ST_SETTLE: begin
               if (dly_q == 32'(SETTLE_CYCLES - 1)) begin
                  if (!rom_not_done) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (!eng_busy) begin
                     ra_q    <= rom_data[15:8];
                     val_q   <= rom_data[7:0];
                     go_q    <= 1'b1;
                     state_q <= ST_XFER;
                  end
               end else begin
                  dly_q <= dly_q + 32'd1;
               end
            end
            ST_XFER: begin
               if (eng_done) begin
                  dly_q <= '0;
                  if (is_soft_reset(ra_q, val_q)) begin
                     state_q <= ST_SW_RST_WAIT;
                  end else begin
                     state_q     <= ST_ADVANCE;
                     rom_next_q  <= 1'b1;
                     reg_count_q <= reg_count_d;
                  end
               end
            end
            ST_SW_RST_WAIT: begin
               if (dly_q == 32'(SWRST_CYCLES - 1)) begin
                  state_q     <= ST_ADVANCE;
                  rom_next_q  <= 1'b1;
                  reg_count_q <= reg_count_d;
               end else begin
                  dly_q <= dly_q + 32'd1;
               end
            end
            ST_ADVANCE: begin
               state_q <= ST_SETTLE;
               dly_q   <= '0;
            end
            ST_DONE: state_q <= ST_DONE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   sccb_write_engine #(
      .QDIV (QDIV)
   ) u_engine (
      .clk_i      (camera_clk),
      .rst_ni     (rst),
      .go_i       (go_q),
      .dev_i      (DEV_ADDR),
      .reg_i      (ra_q),
      .val_i      (val_q),
      .busy_o     (eng_busy),
      .done_o     (eng_done),
      .sio_c_o    (sio_c),
      .sio_d_o    (sio_d_o),
      .sio_d_oe_o (sio_d_oe)
   );

   assign rom_next  = rom_next_q;
   assign cfg_busy  = busy_q;
   assign cfg_done  = done_q;
   assign reg_count = reg_count_q;

endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// Bench for camera_cfg_sequencer: registered ROM model, SCCB bus decoder and a
// ROM-driven expectation of the write sequence, gaps and counters.
module tb_camera_cfg_sequencer;

   localparam int unsigned CLK_HZ  = 800;
   localparam int unsigned SCCB_HZ = 100;
   localparam int unsigned PWR     = 20;
   localparam int unsigned SWR     = 20;
   localparam int unsigned BITP    = 8;
   localparam logic [7:0]  DEV     = 8'h60;

   logic        camera_clk = 1'b0;
   logic        rst        = 1'b0;
   logic        start      = 1'b0;
   logic [15:0] rom_data;
   logic        rom_not_done;
   logic        rom_next;
   logic        sio_c;
   logic        sio_d_o;
   logic        sio_d_oe;
   logic        cfg_busy;
   logic        cfg_done;
   logic [7:0]  reg_count;

   always #5 camera_clk = ~camera_clk;

   camera_cfg_sequencer #(
      .CLK_HZ       (CLK_HZ),
      .SCCB_HZ      (SCCB_HZ),
      .DEV_ADDR     (DEV),
      .PWRUP_CYCLES (PWR),
      .SWRST_CYCLES (SWR)
   ) dut (
      .camera_clk   (camera_clk),
      .rst          (rst),
      .start        (start),
      .rom_data     (rom_data),
      .rom_not_done (rom_not_done),
      .rom_next     (rom_next),
      .sio_c        (sio_c),
      .sio_d_o      (sio_d_o),
      .sio_d_oe     (sio_d_oe),
      .cfg_busy     (cfg_busy),
      .cfg_done     (cfg_done),
      .reg_count    (reg_count)
   );

   // Registered ROM with one cycle of latency; index rewinds on reset.
   logic [15:0] rom_mem [16];
   int unsigned rom_len = 0;
   int unsigned rom_idx = 0;

   always @(posedge camera_clk or negedge rst) begin
      if (!rst) begin
         rom_idx  <= 0;
         rom_data <= '0;
      end else begin
         rom_data <= rom_mem[rom_idx % 16];
         if (rom_next) rom_idx <= rom_idx + 1;
      end
   end
   assign rom_not_done = (rom_idx < rom_len);

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int unsigned act, input int unsigned lo,
                            input int unsigned hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // SCCB bus decoder, sampled on the falling clock edge.
   int unsigned cyc = 0;
   logic        pc = 1'b1;
   logic        pd = 1'b1;
   logic [26:0] fr = '0;
   int unsigned nbits = 0;
   bit          in_frame = 0;
   bit          have_stop = 0;
   int unsigned last_stop = 0;
   int unsigned c_edges = 0;
   int unsigned next_pulses = 0;
   int unsigned bit_viol = 0;
   int unsigned oe_viol = 0;
   logic [23:0] cap_q [$];
   int unsigned gap_q [$];
   logic        line_d;

   assign line_d = sio_d_oe ? sio_d_o : 1'b1;

   task automatic mon_step();
      cyc++;
      if (!rst) begin
         in_frame  = 0;
         have_stop = 0;
         pc        = 1'b1;
         pd        = 1'b1;
         return;
      end
      if (rom_next) next_pulses++;
      if (pc != sio_c) c_edges++;
      if (pc && sio_c && pd && !line_d) begin
         if (in_frame) bit_viol++;
         if (have_stop) gap_q.push_back(cyc - last_stop);
         in_frame = 1;
         nbits    = 0;
      end else if (pc && sio_c && !pd && line_d) begin
         if (in_frame && nbits == 27) cap_q.push_back({fr[26:19], fr[17:10], fr[8:1]});
         else bit_viol++;
         in_frame  = 0;
         have_stop = 1;
         last_stop = cyc;
      end
      if (!pc && sio_c && in_frame && nbits < 27) begin
         fr[26 - nbits] = line_d;
         if (((nbits % 9) == 8) == sio_d_oe) oe_viol++;
         nbits++;
      end
      pc = sio_c;
      pd = line_d;
   endtask

   initial forever begin
      @(negedge camera_clk);
      mon_step();
   end

   task automatic apply_reset();
      @(posedge camera_clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge camera_clk);
      cap_q.delete();
      gap_q.delete();
      c_edges     = 0;
      next_pulses = 0;
      bit_viol    = 0;
      oe_viol     = 0;
      #1;
      rst = 1'b1;
   endtask

   task automatic pulse_start();
      @(posedge camera_clk);
      #1;
      start = 1'b1;
      @(posedge camera_clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int unsigned budget);
      for (int unsigned k = 0; k < budget; k++) begin
         @(posedge camera_clk);
         #1;
         if (cfg_done) break;
      end
      chk({name, " done_in_time"}, 32'(cfg_done), 32'd1);
   endtask

   function automatic bit soft_rst(input logic [15:0] e);
      return (e[15:8] == 8'h12) && e[7];
   endfunction

   // Runs the ROM currently loaded and compares against what its entries imply.
   task automatic check_run(input string tag, input int unsigned n, input logic [7:0] exp_cnt);
      apply_reset();
      pulse_start();
      wait_done(tag, PWR + n * 400 + 200);
      repeat (20) @(posedge camera_clk);
      #1;
      chk({tag, " busy"}, 32'(cfg_busy), 32'd0);
      chk({tag, " reg_count"}, 32'(reg_count), 32'(exp_cnt));
      chk({tag, " rom_next_pulses"}, next_pulses, n);
      chk({tag, " writes"}, cap_q.size(), n);
      for (int unsigned i = 0; i < n && i < cap_q.size(); i++)
         chk($sformatf("%s write%0d", tag, i), 32'(cap_q[i]), 32'({DEV, rom_mem[i]}));
      chk({tag, " gaps"}, gap_q.size(), (n > 0) ? n - 1 : 0);
      for (int unsigned i = 0; i < gap_q.size(); i++) begin
         if (soft_rst(rom_mem[i])) chk_range($sformatf("%s swrst_gap%0d", tag, i), gap_q[i], SWR + BITP, 2000);
         else chk_range($sformatf("%s gap%0d", tag, i), gap_q[i], BITP, SWR + BITP - 1);
      end
      chk({tag, " sda_while_scl_high"}, bit_viol, 0);
      chk({tag, " oe_per_bit"}, oe_viol, 0);
      if (n == 0) chk({tag, " no_scl_edges"}, c_edges, 0);
   endtask

   typedef struct {
      logic [15:0] ent [4];
      int unsigned n;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0].ent = '{16'hFF01, 16'h3C32, 16'h1101, 16'h0000}; vecs[0].n = 3; vecs[0].exp_cnt = 8'd3;
      vecs[1].ent = '{16'h1280, 16'h1101, 16'h0000, 16'h0000}; vecs[1].n = 2; vecs[1].exp_cnt = 8'd2;
      vecs[2].ent = '{16'h127F, 16'h1380, 16'h1280, 16'hFF00}; vecs[2].n = 4; vecs[2].exp_cnt = 8'd4;
      vecs[3].ent = '{16'hA5C3, 16'h0000, 16'h0000, 16'h0000}; vecs[3].n = 1; vecs[3].exp_cnt = 8'd1;
      vecs[4].ent = '{16'h0000, 16'h0000, 16'h0000, 16'h0000}; vecs[4].n = 0; vecs[4].exp_cnt = 8'd0;

      // Reset values, then a start coinciding with reset release must be ignored.
      repeat (3) @(posedge camera_clk);
      #1;
      chk("rst sio_c", 32'(sio_c), 32'd1);
      chk("rst sio_d_oe", 32'(sio_d_oe), 32'd0);
      chk("rst sio_d_o", 32'(sio_d_o), 32'd1);
      chk("rst busy", 32'(cfg_busy), 32'd0);
      chk("rst done", 32'(cfg_done), 32'd0);
      chk("rst reg_count", 32'(reg_count), 32'd0);
      chk("rst rom_next", 32'(rom_next), 32'd0);
      rom_mem[0] = 16'hFF01;
      rom_len    = 1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge camera_clk);
      #1;
      start = 1'b0;
      repeat (10000) @(posedge camera_clk);
      #1;
      chk("idle busy", 32'(cfg_busy), 32'd0);
      chk("idle scl_edges", c_edges, 0);
      chk("idle sio_c", 32'(sio_c), 32'd1);
      chk("idle sio_d_oe", 32'(sio_d_oe), 32'd0);

      for (int unsigned v = 0; v < 5; v++) begin
         for (int unsigned i = 0; i < 4; i++) rom_mem[i] = vecs[v].ent[i];
         rom_len = vecs[v].n;
         check_run($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_cnt);
      end

      for (int unsigned r = 0; r < 4; r++) begin
         int unsigned n;
         logic [7:0]  ra;
         logic [7:0]  va;
         n = $urandom_range(4, 1);
         for (int unsigned i = 0; i < n; i++) begin
            case ($urandom_range(3, 0))
               0: ra = 8'h12;
               1: ra = 8'hFF;
               2: ra = 8'h13;
               default: ra = 8'($urandom);
            endcase
            va = 8'($urandom);
            rom_mem[i] = {ra, va};
         end
         rom_len = n;
         check_run($sformatf("rnd%0d", r), n, 8'(n));
      end

      // Reset in the middle of the register byte of write 2, then a clean restart.
      rom_mem[0] = 16'hFF01;
      rom_mem[1] = 16'h3C32;
      rom_mem[2] = 16'h1101;
      rom_len    = 3;
      apply_reset();
      pulse_start();
      for (int unsigned k = 0; k < 3000; k++) begin
         @(negedge camera_clk);
         if (cap_q.size() == 1 && in_frame && nbits >= 12) break;
      end
      chk("mid reached_write2", 32'(cap_q.size() == 1 && in_frame && nbits >= 12), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid sio_c", 32'(sio_c), 32'd1);
      chk("mid sio_d_oe", 32'(sio_d_oe), 32'd0);
      chk("mid busy", 32'(cfg_busy), 32'd0);
      chk("mid reg_count", 32'(reg_count), 32'd0);
      chk("mid rom_next", 32'(rom_next), 32'd0);
      check_run("restart", 3, 8'd3);

      // Empty ROM: done within PWRUP+3 cycles of start, and a later start does nothing.
      rom_len = 0;
      apply_reset();
      @(posedge camera_clk);
      #1;
      start = 1'b1;
      @(posedge camera_clk);
      #1;
      start = 1'b0;
      for (int unsigned k = 1; k <= PWR + 3; k++) begin
         @(posedge camera_clk);
         #1;
         if (cfg_done) break;
      end
      chk("empty done", 32'(cfg_done), 32'd1);
      chk("empty reg_count", 32'(reg_count), 32'd0);
      pulse_start();
      repeat (300) @(posedge camera_clk);
      #1;
      chk("empty restart busy", 32'(cfg_busy), 32'd0);
      chk("empty restart done", 32'(cfg_done), 32'd1);
      chk("empty scl_edges", c_edges, 0);
      chk("empty rom_next_pulses", next_pulses, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
